lcd_usb_pacer: RTL
==================

LCD_USB_PACER -- requirements
Module: lcd_usb_pacer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, bytes of input buffering (power of two, 4..64).
REQ-002 Parameter E_CLKS, default 6, LCD_E high time in clocks (250 ns at 24 MHz).
REQ-003 Parameter WAIT_SHORT, default 960, post-write wait in clocks for data and normal commands (40 us).
REQ-004 Parameter WAIT_LONG, default 39360, post-write wait in clocks for clear/home commands (1.64 ms).
REQ-005 CLK_USB  input  1  sole clock, all logic on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 USB_FWRn  input  1  active-low byte strobe; one byte per clock sampled low.
REQ-008 USB_D  input  8  USB byte, valid when USB_FWRn low.
REQ-009 FIFO_FULL  output  1  buffer holds FIFO_DEPTH bytes.
REQ-010 OVERFLOW  output  1  sticky: a byte was dropped because the buffer was full.
REQ-011 LCD_RS  output  1  0 = instruction, 1 = data.
REQ-012 LCD_RW  output  1  tied 0, write only.
REQ-013 LCD_E  output  1  LCD enable strobe.
REQ-014 LCD_DB  output  8  LCD data bus.

Function
REQ-015 A byte SHALL be pushed at the edge where USB_FWRn is low and FIFO_FULL is low; count increments at that same edge.
REQ-016 A strobe while FIFO_FULL is high SHALL drop the byte and set OVERFLOW; a pop in that same cycle does not admit the byte.
REQ-017 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-018 IDLE with FIFO non-empty SHALL pop one byte at the next edge.
  - Escape flag clear, byte 0x00: set escape flag; stay in IDLE; no LCD cycle.
  - Otherwise: load LCD_DB = byte, LCD_RS = ~escape; clear escape flag; go to SETUP.
REQ-019 After an escape, the next byte SHALL always be a command, including 0x00.
REQ-020 SETUP SHALL last one clock with LCD_E low; then PULSE.
REQ-021 PULSE SHALL hold LCD_E high exactly E_CLKS clocks; then HOLD.
REQ-022 HOLD SHALL last one clock with LCD_E low and LCD_DB/LCD_RS unchanged; then WAIT.
REQ-023 WAIT SHALL count WAIT_LONG clocks if RS=0 and DB[7:2]==0 with DB!=0 (clear/home), else WAIT_SHORT; then IDLE.
REQ-024 LCD_DB and LCD_RS SHALL change only on the IDLE->SETUP edge.
REQ-025 Latency: byte pushed at edge k, FIFO previously empty, FSM in IDLE -> SETUP from edge k+1, LCD_E rises at k+2, falls at k+2+E_CLKS.
REQ-026 Pushes SHALL continue during every FSM state; pointers wrap modulo FIFO_DEPTH.
REQ-027 Wait counter width SHALL hold WAIT_LONG without overflow.

Reset
REQ-028 RST high SHALL force immediately: FSM IDLE, FIFO empty, escape flag 0, OVERFLOW 0, FIFO_FULL 0, LCD_E 0, LCD_RS 1, LCD_DB 0x00, wait counter 0.
REQ-029 RST asserted mid-pulse SHALL drop LCD_E within the reset, with no glitch on release; buffered bytes are discarded.
REQ-030 Release SHALL be synchronized to CLK_USB before it reaches FSM and pointers.

Structure
REQ-031 Package lcd_pkg SHALL hold the FSM state encoding and the default timing constants (E_CLKS, WAIT_SHORT, WAIT_LONG).
REQ-032 Buffer SHALL be a sub-module lcd_byte_fifo (sync FIFO, push/pop/full/empty/count); FSM and escape logic stay in lcd_usb_pacer.

Verification
REQ-033 Single byte 0x41 after reset -> LCD_RS=1, LCD_DB=0x41, LCD_E high 6 clocks starting 2 clocks after the strobe edge, then 960 clocks idle.
REQ-034 Bytes 0x00,0x01 -> one cycle only, LCD_RS=0, LCD_DB=0x01, 39360-clock wait; bytes 0x00,0x38 -> RS=0, 960-clock wait.
REQ-035 Bytes 0x00,0x00 -> one instruction cycle with LCD_DB=0x00; escape flag clear afterwards (next 0x41 goes out as data).
REQ-036 20 back-to-back strobes with FIFO_DEPTH=16 while the FSM is busy -> FIFO_FULL high, OVERFLOW set, exactly 17 LCD cycles in original order (1 popped at once + 16 buffered).
REQ-037 RST pulse during PULSE of byte 0x55 with 3 bytes queued -> LCD_E low immediately, all outputs at reset values, no LCD cycle after release until new strobes.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the USB-to-HD44780 byte pacer: FSM encoding,
// default bus timing at 24 MHz, and the clear/home command classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam int DEF_E_CLKS     = 6;      // 250 ns enable pulse
  localparam int DEF_WAIT_SHORT = 960;    // 40 us settle for data / normal commands
  localparam int DEF_WAIT_LONG  = 39360;  // 1.64 ms settle for clear / home

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return (rs == 1'b0) && (db[7:2] == 6'd0) && (db != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; pushes are refused when full
// and pops are ignored when empty.
module lcd_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are valid, so a reset costs no clearing logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_usb_pacer.sv
// Buffers bytes from a USB FIFO strobe and replays them as paced HD44780
// write cycles; a 0x00 escape marks the following byte as an instruction.
module lcd_usb_pacer
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int E_CLKS     = DEF_E_CLKS,
  parameter int WAIT_SHORT = DEF_WAIT_SHORT,
  parameter int WAIT_LONG  = DEF_WAIT_LONG
) (
  input  logic       CLK_USB,
  input  logic       RST,
  input  logic       USB_FWRn,
  input  logic [7:0] USB_D,
  output logic       FIFO_FULL,
  output logic       OVERFLOW,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAX_AB  = (WAIT_LONG > WAIT_SHORT) ? WAIT_LONG : WAIT_SHORT;
  localparam int CNT_MAX = (MAX_AB > E_CLKS) ? MAX_AB : E_CLKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [1:0]    rst_sync;
  logic          rst_int;

  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          esc_q, esc_n;
  logic [7:0]    db_q, db_n;
  logic          rs_q, rs_n;
  logic          e_q, e_n;
  logic          ovf_q;

  // Assertion is immediate through the async set; release is retimed to the
  // clock so the FSM and FIFO pointers all leave reset on the same edge.
  always_ff @(posedge CLK_USB or posedge RST) begin
    if (RST) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  lcd_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK_USB),
    .rst   (rst_int),
    .push  (!USB_FWRn),
    .pop   (fifo_pop),
    .din   (USB_D),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  fifo_flags_consistent: assert property (@(posedge CLK_USB) disable iff (rst_int)
    fifo_full == (fifo_count == (AW + 1)'(FIFO_DEPTH)));

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    esc_n    = esc_q;
    db_n     = db_q;
    rs_n     = rs_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!esc_q && fifo_dout == 8'h00) begin
            esc_n = 1'b1;
          end else begin
            db_n    = fifo_dout;
            rs_n    = !esc_q;
            esc_n   = 1'b0;
            state_n = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        state_n = ST_PULSE;
        cnt_n   = CW'(E_CLKS - 1);
      end
      ST_PULSE: begin
        if (cnt_q == '0) state_n = ST_HOLD;
        else             cnt_n   = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        state_n = ST_WAIT;
        cnt_n   = is_long_cmd(rs_q, db_q) ? CW'(WAIT_LONG - 1) : CW'(WAIT_SHORT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_n = ST_IDLE;
        else             cnt_n   = cnt_q - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    e_n = (state_n == ST_PULSE);
  end

  always_ff @(posedge CLK_USB or posedge rst_int) begin
    if (rst_int) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      esc_q   <= 1'b0;
      db_q    <= 8'h00;
      rs_q    <= 1'b1;
      e_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      esc_q   <= esc_n;
      db_q    <= db_n;
      rs_q    <= rs_n;
      e_q     <= e_n;
      if (!USB_FWRn && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign FIFO_FULL = fifo_full;
  assign OVERFLOW  = ovf_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_E     = e_q;
  assign LCD_DB    = db_q;

endmodule
